// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state encoding and pointer sizing helper for regfile_mp
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: clear sequencer that sweeps every register to zero after reset or on i_clr
//   i_clk, i_rst_n  clock, synchronous active-low reset (restarts the sweep)
//   i_clr           start a sweep from IDLE; ignored while sweeping
//   o_busy          sweep in progress
//   o_clr_we        storage write strobe for the sweep
//   o_clr_addr      register being zeroed this cycle
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = (state == ST_CLEAR) ? ((ptr == LAST) ? ST_IDLE : ST_CLEAR)
                                       : (i_clr ? ST_CLEAR : ST_IDLE);
        ptr_nx   = (state == ST_CLEAR) ? ptr + 1'b1 : '0;
    end

    always_comb begin
        o_busy     = state == ST_CLEAR;
        o_clr_we   = state == ST_CLEAR;
        o_clr_addr = ptr;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read, single-write register file with registered reads and clear sweep
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_raddr         NRD read addresses, port k at [k*AW +: AW]
//   o_rdata         NRD registered read data, port k at [k*DW +: DW]
//   i_waddr/i_wdata/i_we  write port, accepted only when idle
//   i_clr           start a clear sweep; o_busy high while sweeping
//   REGFILE_BYPASS_EN defined: write-first same-cycle read; undefined: read-first
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DW       = 32,
    parameter  int DEPTH    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = ptr_w(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NRD*AW-1:0] i_raddr,
    output logic [NRD*DW-1:0] o_rdata,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DW-1:0]     i_wdata,
    input  logic              i_we,
    input  logic              i_clr,
    output logic              o_busy
);

    localparam int NA = 1 << AW;
    // One bit per encodable address: set where the register exists and is writable/readable.
    localparam logic [NA-1:0] ADDR_OK = ({NA{1'b1}} >> (NA - DEPTH)) & ~NA'(ZERO_REG != 0);

    logic [DW-1:0]     mem [NA];
    logic              clr_we;
    logic [AW-1:0]     clr_addr;
    logic              wr_ok;
    logic [NRD*DW-1:0] rd_nx;

    regfile_clr_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clr_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .o_busy     (o_busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // A clear request wins over a write in the same cycle.
    assign wr_ok = i_rst_n && !o_busy && !i_clr && i_we && ADDR_OK[i_waddr];

    always_ff @(posedge i_clk) begin
        if (clr_we && i_rst_n)
            mem[clr_addr] <= '0;
        else if (wr_ok)
            mem[i_waddr] <= i_wdata;
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] ra;
            assign ra = i_raddr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            assign rd_nx[k*DW +: DW] = !ADDR_OK[ra] ? '0 : (wr_ok && ra == i_waddr) ? i_wdata : mem[ra];
`else
            assign rd_nx[k*DW +: DW] = !ADDR_OK[ra] ? '0 : mem[ra];
`endif
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        o_rdata <= (!i_rst_n || o_busy) ? '0 : rd_nx;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp with table vectors, corner sequences and a random reference model
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [NRD*AW-1:0] i_raddr;
    logic [NRD*DW-1:0] o_rdata;
    logic [AW-1:0]     i_waddr;
    logic [DW-1:0]     i_wdata;
    logic              i_we;
    logic              i_clr;
    logic              o_busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] mdl_rd  [NRD];
    int            busy_left = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;
    vec_t tbl [7];

    always #5 i_clk = ~i_clk;

    regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raddr (i_raddr),
        .o_rdata (o_rdata),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_we    (i_we),
        .i_clr   (i_clr),
        .o_busy  (o_busy)
    );

    function automatic logic [AW-1:0] ra(input int k);
        return i_raddr[k*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] rd(input int k);
        return o_rdata[k*DW +: DW];
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Reference: reset or clear arms a DEPTH-cycle sweep zeroing registers in address order;
    // idle reads see old contents (or the incoming write when bypassing); r0 always reads 0.
    task automatic model_edge();
        if (!i_rst_n) begin
            busy_left = DEPTH;
            foreach (mdl_rd[k]) mdl_rd[k] = '0;
        end else if (busy_left > 0) begin
            mdl_mem[DEPTH - busy_left] = '0;
            busy_left--;
            foreach (mdl_rd[k]) mdl_rd[k] = '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                int a;
                a = int'(ra(k));
                mdl_rd[k] = (a == 0) ? '0
                          : (BYPASS && i_we && !i_clr && a == int'(i_waddr)) ? i_wdata
                          : mdl_mem[a];
            end
            if (i_clr) busy_left = DEPTH;
            else if (i_we && i_waddr != 0) mdl_mem[i_waddr] = i_wdata;
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        model_edge();
        #1;
        chk("busy", DW'(o_busy), DW'(busy_left > 0));
        for (int k = 0; k < NRD; k++) chk($sformatf("rdata%0d", k), rd(k), mdl_rd[k]);
        @(negedge i_clk);
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic clr);
        i_we    = we;
        i_waddr = wa;
        i_wdata = wd;
        i_raddr = {r1, r0};
        i_clr   = clr;
    endtask

    // Counts sampled cycles with o_busy high, starting from the triggering edge already sampled.
    task automatic count_busy(input string nm);
        int n, g;
        n = o_busy ? 1 : 0;
        g = 0;
        while (o_busy && g < 100) begin
            step();
            g++;
            if (o_busy) n++;
        end
        chk(nm, DW'(n), DW'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (mdl_mem[a]) mdl_mem[a] = '0;
        foreach (mdl_rd[k]) mdl_rd[k] = '0;
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5,
                   BYPASS ? 32'hA5A5A5A5 : 32'h11111111, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};

        drive(1'b0, '0, '0, '0, '0, 1'b0);
        i_rst_n = 1'b0;
        step();
        step();
        chk("rst_rdata", o_rdata[DW-1:0] | o_rdata[2*DW-1:DW], '0);
        chk("rst_busy", DW'(o_busy), 32'd1);
        i_rst_n = 1'b1;
        count_busy("init_busy_len");

        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, AW'(a), AW'(DEPTH - 1 - a), 1'b0);
            step();
        end
        step();

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1, 1'b0);
            step();
            chk($sformatf("tbl%0d_p0", i), rd(0), tbl[i].e0);
            chk($sformatf("tbl%0d_p1", i), rd(1), tbl[i].e1);
        end

        drive(1'b1, 5'd3, 32'hCAFE, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b1, 5'd4, 32'hBEEF, 5'd3, 5'd4, 1'b1);
        step();
        drive(1'b0, '0, '0, 5'd3, 5'd4, 1'b0);
        count_busy("clr_busy_len");
        step();
        chk("clr_r3", rd(0), '0);
        chk("clr_r4", rd(1), '0);

        drive(1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b1);
        step();
        i_clr = 1'b0;
        repeat (9) step();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        drive(1'b1, 5'd9, 32'h1, 5'd9, 5'd9, 1'b0);
        count_busy("rst_mid_busy_len");
        drive(1'b0, '0, '0, 5'd9, 5'd9, 1'b0);
        step();
        chk("mid_sweep_r9", rd(0), '0);

        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, DEPTH - 1));
            i_rst_n = ($urandom_range(0, 199) != 0);
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 39) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
